// File: rtl/wb_port_arbiter_if.sv
// Regfile write-port bus between the three writers and the write-port arbiter.
//
// Handshake: md_ready_o / amo_ready_o are same-cycle combinational grants. A
// transfer happens on a rising clk edge where valid && ready are both 1. Until
// then the source keeps valid high and its rd/data stable. After a transfer it
// drops valid or presents its next result. The pipeline has no ready signal.
// It writes whenever pipe_we_i is 1, except while stall_pipe_o is 1. In that
// case it holds its writeback and presents it again on the following cycle.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_we_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_data_i;
  logic            md_valid_i;
  logic [4:0]      md_rd_i;
  logic [XLEN-1:0] md_data_i;
  logic            md_ready_o;
  logic            amo_valid_i;
  logic [4:0]      amo_rd_i;
  logic [XLEN-1:0] amo_data_i;
  logic            amo_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_rd_o;
  logic [XLEN-1:0] rf_wd_o;
  logic            stall_pipe_o;

  // Writer side: pipeline, mul/div and AMO units (the bench in simulation).
  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i,
    output md_valid_i, md_rd_i, md_data_i,
    output amo_valid_i, amo_rd_i, amo_data_i,
    input  md_ready_o, amo_ready_o,
    input  rf_we_o, rf_rd_o, rf_wd_o, stall_pipe_o
  );

  // Arbiter side.
  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i,
    input  md_valid_i, md_rd_i, md_data_i,
    input  amo_valid_i, amo_rd_i, amo_data_i,
    output md_ready_o, amo_ready_o,
    output rf_we_o, rf_rd_o, rf_wd_o, stall_pipe_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the integer regfile write port between pipeline writeback, mul/div
// and AMO. The pipeline has priority. The two long-latency units round-robin
// between themselves. When a long-latency result is denied STARVE_LIMIT cycles
// in a row, the arbiter stalls the pipeline for one cycle to free a slot.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic                clk,
  input  logic                rst,
  wb_port_arbiter_if.slave    bus,
  output logic                dbg_state_o,      // 1 while in STEAL
  output logic [3:0]          dbg_starve_cnt_o
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STEAL  = 1'b1
  } state_e;

  localparam logic RR_MD  = 1'b0;
  localparam logic RR_AMO = 1'b1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e          state_q, state_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic            stall_q, stall_d;
  logic            md_gnt, amo_gnt, any_ll_valid;

  // Grant selection and next-state for every register of the arbiter.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wd_d      = rf_wd_q;
    stall_d      = 1'b0;
    md_gnt       = 1'b0;
    amo_gnt      = 1'b0;
    any_ll_valid = bus.md_valid_i || bus.amo_valid_i;

    // Nothing is granted while in reset, so no source sees a transfer that
    // the reset is about to discard.
    if (!rst) begin
      if (state_q == ST_NORMAL && bus.pipe_we_i) begin
        rf_we_d = (bus.pipe_rd_i != 5'd0);
        rf_rd_d = bus.pipe_rd_i;
        rf_wd_d = bus.pipe_data_i;
      end else if (bus.md_valid_i && bus.amo_valid_i) begin
        md_gnt  = (rr_ptr_q == RR_MD);
        amo_gnt = (rr_ptr_q == RR_AMO);
      end else begin
        md_gnt  = bus.md_valid_i;
        amo_gnt = bus.amo_valid_i;
      end
    end

    if (md_gnt) begin
      rf_we_d  = (bus.md_rd_i != 5'd0);
      rf_rd_d  = bus.md_rd_i;
      rf_wd_d  = bus.md_data_i;
      rr_ptr_d = RR_AMO;
    end else if (amo_gnt) begin
      rf_we_d  = (bus.amo_rd_i != 5'd0);
      rf_rd_d  = bus.amo_rd_i;
      rf_wd_d  = bus.amo_data_i;
      rr_ptr_d = RR_MD;
    end

    if (state_q == ST_NORMAL) begin
      if (md_gnt || amo_gnt || !any_ll_valid) begin
        starve_cnt_d = 4'd0;
      end else if (starve_cnt_q >= LIMIT) begin
        starve_cnt_d = LIMIT;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
      if (starve_cnt_d == LIMIT) begin
        stall_d = 1'b1;
        state_d = ST_STEAL;
      end
    end else begin
      // The stolen slot lasts exactly one cycle, whether or not it was used.
      starve_cnt_d = 4'd0;
      state_d      = ST_NORMAL;
    end
  end

  // Single state register for the FSM and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= 4'd0;
      rr_ptr_q     <= RR_MD;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wd_q      <= '0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wd_q      <= rf_wd_d;
      stall_q      <= stall_d;
    end
  end

  assign bus.md_ready_o   = md_gnt;
  assign bus.amo_ready_o  = amo_gnt;
  assign bus.rf_we_o      = rf_we_q;
  assign bus.rf_rd_o      = rf_rd_q;
  assign bus.rf_wd_o      = rf_wd_q;
  assign bus.stall_pipe_o = stall_q;
  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, round-robin, pipeline priority,
// starvation steal, x0 writes, empty steal slot and reset during a steal.
module tb_wb_port_arbiter;

  localparam int XLEN = 32;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [3:0] dbg_cnt;
  int         checks;
  int         errors;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_port_arbiter #(.STARVE_LIMIT(4), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .dbg_state_o      (dbg_state),
    .dbg_starve_cnt_o (dbg_cnt)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge. Registered outputs are stable
  // there, and new inputs can be applied.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Driver tasks.
  task automatic drive_pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_we_i   = we;
    bus.pipe_rd_i   = rd;
    bus.pipe_data_i = d;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.md_valid_i = v;
    bus.md_rd_i    = rd;
    bus.md_data_i  = d;
  endtask

  task automatic drive_amo(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.amo_valid_i = v;
    bus.amo_rd_i    = rd;
    bus.amo_data_i  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_md(1'b1, 5'd10, 32'h100);
    drive_amo(1'b1, 5'd20, 32'h200);

    // Reset with both long-latency valids high.
    tick();
    tick();
    #1;
    check("rst_we", bus.rf_we_o, 1'b0);
    check("rst_stall", bus.stall_pipe_o, 1'b0);
    check("rst_md_rdy", bus.md_ready_o, 1'b0);
    check("rst_amo_rdy", bus.amo_ready_o, 1'b0);
    check("rst_rd", bus.rf_rd_o, 5'd0);
    check("rst_wd", bus.rf_wd_o, 32'h0);
    rst = 1'b0;

    // Round-robin: md, amo, md, amo. Each source advances after acceptance.
    begin
      logic [4:0]  exp_rd [4];
      logic [31:0] exp_wd [4];
      logic        exp_md [4];
      exp_md = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_rd = '{5'd10, 5'd20, 5'd11, 5'd21};
      exp_wd = '{32'h100, 32'h200, 32'h101, 32'h201};
      for (int k = 0; k < 4; k++) begin
        #1;
        check($sformatf("rr%0d_md_rdy", k), bus.md_ready_o, exp_md[k]);
        check($sformatf("rr%0d_amo_rdy", k), bus.amo_ready_o, !exp_md[k]);
        tick();
        check($sformatf("rr%0d_we", k), bus.rf_we_o, 1'b1);
        check($sformatf("rr%0d_rd", k), bus.rf_rd_o, exp_rd[k]);
        check($sformatf("rr%0d_wd", k), bus.rf_wd_o, exp_wd[k]);
        if (exp_md[k]) drive_md(1'b1, bus.md_rd_i + 5'd1, bus.md_data_i + 32'd1);
        else           drive_amo(1'b1, bus.amo_rd_i + 5'd1, bus.amo_data_i + 32'd1);
      end
    end

    // Pipeline priority over a pending md result.
    drive_pipe(1'b1, 5'd5, 32'h1234);
    drive_md(1'b1, 5'd3, 32'h33);
    drive_amo(1'b0, 5'd0, 32'h0);
    #1;
    check("pri_md_rdy", bus.md_ready_o, 1'b0);
    check("pri_amo_rdy", bus.amo_ready_o, 1'b0);
    tick();
    check("pri_we", bus.rf_we_o, 1'b1);
    check("pri_rd", bus.rf_rd_o, 5'd5);
    check("pri_wd", bus.rf_wd_o, 32'h1234);
    check("pri_cnt", dbg_cnt, 4'd1);

    // Idle cycle: no grant, address/data hold, counter clears.
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_md(1'b0, 5'd0, 32'h0);
    tick();
    check("idle_we", bus.rf_we_o, 1'b0);
    check("idle_rd_hold", bus.rf_rd_o, 5'd5);
    check("idle_wd_hold", bus.rf_wd_o, 32'h1234);
    check("idle_cnt", dbg_cnt, 4'd0);

    // Starvation: pipeline writes every cycle while AMO waits.
    drive_pipe(1'b1, 5'd9, 32'h55);
    drive_amo(1'b1, 5'd7, 32'hDEAD);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("stv%0d_amo_rdy", k), bus.amo_ready_o, 1'b0);
      check($sformatf("stv%0d_stall", k), bus.stall_pipe_o, 1'b0);
      tick();
      check($sformatf("stv%0d_rd", k), bus.rf_rd_o, 5'd9);
      check($sformatf("stv%0d_cnt", k), dbg_cnt, 4'(k));
    end
    #1;
    check("steal_stall", bus.stall_pipe_o, 1'b1);
    check("steal_state", dbg_state, 1'b1);
    check("steal_amo_rdy", bus.amo_ready_o, 1'b1);
    check("steal_md_rdy", bus.md_ready_o, 1'b0);
    tick();
    check("steal_we", bus.rf_we_o, 1'b1);
    check("steal_rd", bus.rf_rd_o, 5'd7);
    check("steal_wd", bus.rf_wd_o, 32'hDEAD);
    check("steal_stall_clr", bus.stall_pipe_o, 1'b0);
    check("steal_cnt_clr", dbg_cnt, 4'd0);
    check("steal_state_clr", dbg_state, 1'b0);

    // x0 destination: consumed but not written.
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_amo(1'b0, 5'd0, 32'h0);
    drive_md(1'b1, 5'd0, 32'hFFFF);
    #1;
    check("x0_md_rdy", bus.md_ready_o, 1'b1);
    tick();
    check("x0_we", bus.rf_we_o, 1'b0);
    drive_md(1'b0, 5'd0, 32'h0);

    // Steal slot with no source still valid: no write, back to NORMAL.
    drive_pipe(1'b1, 5'd9, 32'h55);
    drive_amo(1'b1, 5'd7, 32'hBEEF);
    repeat (4) tick();
    check("empty_stall", bus.stall_pipe_o, 1'b1);
    drive_amo(1'b0, 5'd0, 32'h0);
    #1;
    check("empty_amo_rdy", bus.amo_ready_o, 1'b0);
    tick();
    check("empty_we", bus.rf_we_o, 1'b0);
    check("empty_stall_clr", bus.stall_pipe_o, 1'b0);
    check("empty_state", dbg_state, 1'b0);

    // Reset during STEAL: the in-flight grant is dropped.
    drive_amo(1'b1, 5'd7, 32'hCAFE);
    repeat (4) tick();
    check("rsteal_stall", bus.stall_pipe_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rsteal_amo_rdy", bus.amo_ready_o, 1'b0);
    tick();
    check("rsteal_stall_clr", bus.stall_pipe_o, 1'b0);
    check("rsteal_we", bus.rf_we_o, 1'b0);
    check("rsteal_cnt", dbg_cnt, 4'd0);
    check("rsteal_state", dbg_state, 1'b0);
    rst = 1'b0;
    tick();
    check("rsteal_cnt_restart", dbg_cnt, 4'd1);
    check("rsteal_pipe_rd", bus.rf_rd_o, 5'd9);

    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_amo(1'b0, 5'd0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
